// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Operand-side issue controller for the 4-bit ALU. A command (a, b, function)
// is accepted over a valid/ready handshake and loaded into registers that
// drive the ALU inputs directly. Those inputs are held for SETTLE_CYCLES clock
// edges, then the combinational ALU result is captured and returned with
// zero / illegal-function / self-check flags over a second valid/ready
// handshake. op_count counts completed responses, modulo 256.
//
// Parameters
//   SETTLE_CYCLES  edges the ALU inputs are held before capture (1..15)
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   cmd_valid     command present
//   cmd_ready     controller idle and able to accept a command
//   cmd_a/cmd_b   4-bit operands
//   cmd_func      function code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5..7 illegal
//   alu_a/alu_b   registered operands to the ALU
//   alu_function  registered function code to the ALU
//   alu_result    combinational ALU result
//   rsp_valid     response present
//   rsp_ready     consumer accepts the response
//   rsp_result    captured ALU result
//   rsp_zero      rsp_result == 0
//   rsp_err       captured command used an illegal function code
//   rsp_mismatch  captured result differs from the locally expected result
//   op_count      completed responses, wraps 255 -> 0
//
// Build option
//   ALU_ISSUE_SELFCHECK_EN  when defined, the controller recomputes the
//                           expected result from its own registered operands
//                           and flags disagreement on rsp_mismatch; when
//                           undefined, rsp_mismatch is tied low.
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [2:0] cmd_func,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_function,
  input  logic [3:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_result,
  output logic       rsp_zero,
  output logic       rsp_err,
  output logic       rsp_mismatch,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESPOND
  } state_t;

  localparam logic [2:0] FN_ADD = 3'd0;
  localparam logic [2:0] FN_SUB = 3'd1;
  localparam logic [2:0] FN_AND = 3'd2;
  localparam logic [2:0] FN_OR  = 3'd3;
  localparam logic [2:0] FN_XOR = 3'd4;

  // Counter value on the edge that samples alu_result.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] settle_cnt;
  logic       accept;
  logic       capture;
  logic       handshake;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (settle_cnt == SETTLE_LAST) begin
          capture   = 1'b1;
          state_nxt = RESPOND;
        end
      end
      RESPOND: begin
        if (rsp_valid && rsp_ready) begin
          handshake = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Settle counter: cleared on acceptance, counts edges spent in ISSUE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      settle_cnt <= '0;
    end else if (accept) begin
      settle_cnt <= '0;
    end else if ((state == ISSUE) && !capture) begin
      settle_cnt <= settle_cnt + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // ALU operand registers: change only on acceptance so the ALU inputs stay
  // glitch-free through ISSUE and RESPOND.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_function <= '0;
      rsp_err      <= 1'b0;
    end else if (accept) begin
      alu_a        <= cmd_a;
      alu_b        <= cmd_b;
      alu_function <= cmd_func;
      rsp_err      <= (cmd_func > FN_XOR);
    end
  end

  // ---------------------------------------------------------------------------
  // Response registers and completion counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      op_count   <= '0;
    end else if (capture) begin
      rsp_valid  <= 1'b1;
      rsp_result <= alu_result;
      rsp_zero   <= (alu_result == 4'd0);
    end else if (handshake) begin
      rsp_valid  <= 1'b0;
      op_count   <= op_count + 8'd1;
    end
  end

`ifdef ALU_ISSUE_SELFCHECK_EN
  // Reference result from the registered operands, i.e. exactly what the ALU
  // is being driven with at the capture edge.
  logic [3:0] expected;

  always_comb begin
    expected = '0;
    case (alu_function)
      FN_ADD:  expected = alu_a + alu_b;
      FN_SUB:  expected = alu_a - alu_b;
      FN_AND:  expected = alu_a & alu_b;
      FN_OR:   expected = alu_a | alu_b;
      FN_XOR:  expected = alu_a ^ alu_b;
      default: expected = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_mismatch <= 1'b0;
    end else if (capture) begin
      rsp_mismatch <= (alu_result != expected);
    end else if (handshake) begin
      rsp_mismatch <= 1'b0;
    end
  end
`else
  assign rsp_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Three controllers (SETTLE_CYCLES = 1, 3, 4), each driving its own stand-in
// ALU. A transaction-level model tracks, per instance, whether a command is
// in flight, how many edges it has aged, and the response it must produce.
// Every DUT output is compared to the model after each falling edge and on
// reset assertion; directed scenarios additionally post literal expectations
// that are checked against both the DUT and the model.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

  localparam int NI = 3;

`ifdef ALU_ISSUE_SELFCHECK_EN
  localparam bit SELF = 1'b1;
`else
  localparam bit SELF = 1'b0;
`endif

  localparam int K_RDY  = 0;
  localparam int K_A    = 1;
  localparam int K_B    = 2;
  localparam int K_FN   = 3;
  localparam int K_VAL  = 4;
  localparam int K_RES  = 5;
  localparam int K_ZERO = 6;
  localparam int K_ERR  = 7;
  localparam int K_MIS  = 8;
  localparam int K_CNT  = 9;
  localparam int NKIND  = 10;

  function automatic int sc(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  // Reference 4-bit ALU behaviour.
  function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] f);
    case (f)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return 4'd0;
    endcase
  endfunction

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] cmd_a    = '0;
  logic [3:0] cmd_b    = '0;
  logic [2:0] cmd_func = '0;

  logic       cmd_valid    [NI];
  logic       rsp_ready    [NI];
  logic       force_en     [NI];
  logic [3:0] force_val    [NI];
  logic       cmd_ready    [NI];
  logic [3:0] alu_a        [NI];
  logic [3:0] alu_b        [NI];
  logic [2:0] alu_function [NI];
  logic [3:0] alu_result   [NI];
  logic       rsp_valid    [NI];
  logic [3:0] rsp_result   [NI];
  logic       rsp_zero     [NI];
  logic       rsp_err      [NI];
  logic       rsp_mismatch [NI];
  logic [7:0] op_count     [NI];

  always #5 clk = ~clk;

  genvar g;
  for (g = 0; g < NI; g++) begin : g_dut
    assign alu_result[g] = force_en[g] ? force_val[g]
                                       : alu_fn(alu_a[g], alu_b[g], alu_function[g]);
    alu_issue_ctrl #(.SETTLE_CYCLES(sc(g))) u_dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_valid    (cmd_valid[g]),
      .cmd_ready    (cmd_ready[g]),
      .cmd_a        (cmd_a),
      .cmd_b        (cmd_b),
      .cmd_func     (cmd_func),
      .alu_a        (alu_a[g]),
      .alu_b        (alu_b[g]),
      .alu_function (alu_function[g]),
      .alu_result   (alu_result[g]),
      .rsp_valid    (rsp_valid[g]),
      .rsp_ready    (rsp_ready[g]),
      .rsp_result   (rsp_result[g]),
      .rsp_zero     (rsp_zero[g]),
      .rsp_err      (rsp_err[g]),
      .rsp_mismatch (rsp_mismatch[g]),
      .op_count     (op_count[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Transaction-level model
  // ---------------------------------------------------------------------------
  bit   m_busy [NI];
  bit   m_rsp  [NI];
  int   m_age  [NI];
  int   m_a    [NI];
  int   m_b    [NI];
  int   m_f    [NI];
  int   m_res  [NI];
  bit   m_zero [NI];
  bit   m_err  [NI];
  bit   m_mis  [NI];
  int   m_cnt  [NI];

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < NI; k++) begin
      if (reset) begin
        m_busy[k] = 1'b0; m_rsp[k] = 1'b0; m_age[k] = 0;
        m_a[k] = 0; m_b[k] = 0; m_f[k] = 0; m_res[k] = 0;
        m_zero[k] = 1'b0; m_err[k] = 1'b0; m_mis[k] = 1'b0; m_cnt[k] = 0;
      end else if (!m_busy[k]) begin
        if (cmd_valid[k]) begin
          m_busy[k] = 1'b1;
          m_age[k]  = 0;
          m_a[k]    = int'(cmd_a);
          m_b[k]    = int'(cmd_b);
          m_f[k]    = int'(cmd_func);
          m_err[k]  = (cmd_func > 3'd4);
        end
      end else if (!m_rsp[k]) begin
        m_age[k] = m_age[k] + 1;
        if (m_age[k] == sc(k)) begin
          logic [3:0] good;
          logic [3:0] fed;
          good      = alu_fn(4'(m_a[k]), 4'(m_b[k]), 3'(m_f[k]));
          fed       = force_en[k] ? force_val[k] : good;
          m_res[k]  = int'(fed);
          m_zero[k] = (fed == 4'd0);
          m_mis[k]  = SELF && (fed != good);
          m_rsp[k]  = 1'b1;
        end
      end else if (rsp_ready[k]) begin
        m_busy[k] = 1'b0;
        m_rsp[k]  = 1'b0;
        m_mis[k]  = 1'b0;
        m_cnt[k]  = (m_cnt[k] + 1) % 256;
      end
    end
  end

  function automatic int dut_f(input int k, input int kind);
    case (kind)
      K_RDY:   return int'(cmd_ready[k]);
      K_A:     return int'(alu_a[k]);
      K_B:     return int'(alu_b[k]);
      K_FN:    return int'(alu_function[k]);
      K_VAL:   return int'(rsp_valid[k]);
      K_RES:   return int'(rsp_result[k]);
      K_ZERO:  return int'(rsp_zero[k]);
      K_ERR:   return int'(rsp_err[k]);
      K_MIS:   return int'(rsp_mismatch[k]);
      default: return int'(op_count[k]);
    endcase
  endfunction

  function automatic int mdl_f(input int k, input int kind);
    case (kind)
      K_RDY:   return int'(!m_busy[k]);
      K_A:     return m_a[k];
      K_B:     return m_b[k];
      K_FN:    return m_f[k];
      K_VAL:   return int'(m_rsp[k]);
      K_RES:   return m_res[k];
      K_ZERO:  return int'(m_zero[k]);
      K_ERR:   return int'(m_err[k]);
      K_MIS:   return int'(m_mis[k]);
      default: return m_cnt[k];
    endcase
  endfunction

  function automatic string fname(input int kind);
    case (kind)
      K_RDY:   return "cmd_ready";
      K_A:     return "alu_a";
      K_B:     return "alu_b";
      K_FN:    return "alu_function";
      K_VAL:   return "rsp_valid";
      K_RES:   return "rsp_result";
      K_ZERO:  return "rsp_zero";
      K_ERR:   return "rsp_err";
      K_MIS:   return "rsp_mismatch";
      default: return "op_count";
    endcase
  endfunction

  // Literal expectations posted by the stimulus, checked at the next compare.
  int lit_k    [512];
  int lit_kind [512];
  int lit_val  [512];
  int lit_wr = 0;
  int lit_rd = 0;

  int n_vec = 0;
  int n_err = 0;

  // ---------------------------------------------------------------------------
  // Compare process
  // ---------------------------------------------------------------------------
  always begin
    @(negedge clk or posedge reset);
    #1;
    for (int k = 0; k < NI; k++) begin
      for (int kind = 0; kind < NKIND; kind++) begin
        int d;
        int m;
        d = dut_f(k, kind);
        m = mdl_f(k, kind);
        n_vec++;
        if (d != m) begin
          n_err++;
          $display("FAIL %s[%0d] dut=%0d model=%0d t=%0t", fname(kind), k, d, m, $time);
        end
      end
    end
    while (lit_rd != lit_wr) begin
      int k;
      int kind;
      int d;
      int m;
      k    = lit_k[lit_rd];
      kind = lit_kind[lit_rd];
      d    = dut_f(k, kind);
      m    = mdl_f(k, kind);
      n_vec += 2;
      if (d != lit_val[lit_rd]) begin
        n_err++;
        $display("FAIL lit_%s[%0d] dut=%0d required=%0d t=%0t",
                 fname(kind), k, d, lit_val[lit_rd], $time);
      end
      if (m != lit_val[lit_rd]) begin
        n_err++;
        $display("FAIL lit_model_%s[%0d] model=%0d required=%0d t=%0t",
                 fname(kind), k, m, lit_val[lit_rd], $time);
      end
      lit_rd++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 2 time units after the falling edge)
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic post(input int k, input int kind, input int val);
    lit_k[lit_wr]    = k;
    lit_kind[lit_wr] = kind;
    lit_val[lit_wr]  = val;
    lit_wr++;
  endtask

  task automatic issue(input int k, input int a, input int b, input int f);
    cmd_a        = 4'(a);
    cmd_b        = 4'(b);
    cmd_func     = 3'(f);
    cmd_valid[k] = 1'b1;
    cyc();
    cmd_valid[k] = 1'b0;
  endtask

  // One complete operation with literal expectations; the response is held
  // for 'hold' cycles with rsp_ready low, and a stray command is offered
  // during the hold when it lasts two or more cycles.
  task automatic op_lit(input int k, input int a, input int b, input int f,
                        input int res, input int zero, input int err,
                        input int mis, input int hold);
    issue(k, a, b, f);
    for (int i = 1; i <= sc(k); i++) begin
      post(k, K_VAL, (i == sc(k)) ? 1 : 0);
      post(k, K_RDY, 0);
      cyc();
    end
    for (int i = 0; i < hold; i++) begin
      post(k, K_VAL, 1);  post(k, K_RDY, 0);
      post(k, K_RES, res); post(k, K_ZERO, zero); post(k, K_ERR, err);
      post(k, K_MIS, mis); post(k, K_FN, f); post(k, K_A, a); post(k, K_B, b);
      if (i == 1) begin
        cmd_a        = ~4'(a);
        cmd_b        = ~4'(b);
        cmd_func     = 3'd3;
        cmd_valid[k] = 1'b1;
      end else begin
        cmd_valid[k] = 1'b0;
      end
      cyc();
    end
    cmd_valid[k] = 1'b0;
    rsp_ready[k] = 1'b1;
    cyc();
    rsp_ready[k] = 1'b0;
    post(k, K_VAL, 0);
    post(k, K_RDY, 1);
    cyc();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  initial begin
    for (int k = 0; k < NI; k++) begin
      cmd_valid[k] = 1'b0;
      rsp_ready[k] = 1'b0;
      force_en[k]  = 1'b0;
      force_val[k] = '0;
    end
    #1;
    reset = 1'b1;
    post(0, K_RDY, 1); post(0, K_VAL, 0); post(0, K_A, 0); post(0, K_FN, 0);
    post(0, K_RES, 0); post(0, K_ERR, 0); post(0, K_MIS, 0); post(0, K_CNT, 0);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();

    // ADD overflow, latency and op_count step on SETTLE_CYCLES = 1
    post(0, K_CNT, 0);
    op_lit(0, 9, 8, 0, 1, 0, 0, 0, 1);
    post(0, K_CNT, 1);
    // SUB borrow, XOR zero, illegal function
    op_lit(0, 3, 5, 1, 4'hE, 0, 0, 0, 1);
    op_lit(0, 5, 5, 4, 0, 1, 0, 0, 1);
    op_lit(0, 7, 2, 6, 0, 1, 1, 0, 1);
    post(0, K_CNT, 4);

    // Forced wrong ALU result, then a correct one
    force_en[0]  = 1'b1;
    force_val[0] = 4'hF;
    op_lit(0, 1, 1, 0, 4'hF, 0, 0, SELF ? 1 : 0, 1);
    force_en[0]  = 1'b0;
    op_lit(0, 1, 1, 0, 2, 0, 0, 0, 1);

    // Backpressure on SETTLE_CYCLES = 3: hold 5 cycles, stray command ignored
    op_lit(1, 4, 3, 1, 1, 0, 0, 0, 5);
    post(1, K_CNT, 1);
    cyc();

    // Reset mid-ISSUE on SETTLE_CYCLES = 4
    op_lit(2, 4'hC, 4'h3, 3, 4'hF, 0, 0, 0, 1);
    issue(2, 5, 6, 0);
    cyc();
    cyc();
    reset = 1'b1;
    post(2, K_RDY, 1); post(2, K_VAL, 0); post(2, K_A, 0); post(2, K_B, 0);
    post(2, K_FN, 0); post(2, K_RES, 0); post(2, K_ZERO, 0); post(2, K_ERR, 0);
    post(2, K_MIS, 0); post(2, K_CNT, 0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      post(2, K_VAL, 0);
      cyc();
    end
    op_lit(2, 5, 6, 0, 4'hB, 0, 0, 0, 1);
    post(2, K_CNT, 1);
    cyc();

    // 256 back-to-back operations on SETTLE_CYCLES = 1
    post(0, K_CNT, 0);
    cyc();
    cmd_valid[0] = 1'b1;
    rsp_ready[0] = 1'b1;
    for (int c = 0; c < 768; c++) begin
      cmd_a    = 4'($urandom);
      cmd_b    = 4'($urandom);
      cmd_func = 3'($urandom);
      if (c == 384) post(0, K_CNT, 128);
      cyc();
    end
    cmd_valid[0] = 1'b0;
    rsp_ready[0] = 1'b0;
    post(0, K_CNT, 0);
    post(0, K_RDY, 1);
    cyc();

    // Randomized traffic on all instances
    for (int c = 0; c < 1500; c++) begin
      reset    = ($urandom_range(0, 299) == 0);
      cmd_a    = 4'($urandom);
      cmd_b    = 4'($urandom);
      cmd_func = 3'($urandom);
      for (int k = 0; k < NI; k++) begin
        cmd_valid[k] = 1'($urandom_range(0, 1));
        rsp_ready[k] = ($urandom_range(0, 3) != 0);
        force_en[k]  = ($urandom_range(0, 7) == 0);
        force_val[k] = 4'($urandom);
      end
      cyc();
    end
    reset = 1'b0;
    for (int k = 0; k < NI; k++) begin
      cmd_valid[k] = 1'b0;
      rsp_ready[k] = 1'b1;
      force_en[k]  = 1'b0;
    end
    for (int i = 0; i < 4; i++) cyc();
    for (int k = 0; k < NI; k++) post(k, K_RDY, 1);
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
